// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: decoder control, program memory port and the fetch
// state presented back to the core.
//   master: decoder / memory side (drives controls and pmem_rdata)
//   slave : instruction_fetch (drives pmem strobe/address and fetch state)
interface instruction_fetch_if #(
  parameter int unsigned PC_WIDTH    = 13,
  parameter int unsigned INSTR_WIDTH = 14
);
  logic                   instr_rd_en;
  logic                   incr_pc_en;
  logic                   branch_en;
  logic [PC_WIDTH-1:0]    branch_addr;
  logic [PC_WIDTH-1:0]    pmem_addr;
  logic                   pmem_rd_en;
  logic [INSTR_WIDTH-1:0] pmem_rdata;
  logic [INSTR_WIDTH-1:0] instr_current;
  logic [PC_WIDTH-1:0]    pc;
  logic [1:0]             q_phase;
  logic                   flush_active;

  modport master (
    output instr_rd_en, incr_pc_en, branch_en, branch_addr, pmem_rdata,
    input  pmem_addr, pmem_rd_en, instr_current, pc, q_phase, flush_active
  );

  modport slave (
    input  instr_rd_en, incr_pc_en, branch_en, branch_addr, pmem_rdata,
    output pmem_addr, pmem_rd_en, instr_current, pc, q_phase, flush_active
  );
endinterface

// File: rtl/instruction_fetch.sv
// PIC16F-style instruction fetch front end.
// Runs the Q1..Q4 phase counter, owns the program counter, prefetches the next
// word from synchronous program memory and presents instr_current to the
// decoder, inserting forced NOPs after reset, on branches and on skips.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - instruction_fetch_if.slave: decoder controls (sampled at Q4),
//          program memory port, instr_current / pc / q_phase / flush_active
module instruction_fetch #(
  parameter int unsigned           PC_WIDTH     = 13,
  parameter int unsigned           INSTR_WIDTH  = 14,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD     = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.slave   bus
);

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_t;

  phase_t                 q_phase_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] fetch_buf_q;
  logic                   flush_q;
  logic                   pmem_rd_en_q;

  // Phase sequencing, prefetch and Q4 commit of pc / instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      q_phase_q    <= Q1;
      pc_q         <= RESET_VECTOR;
      instr_q      <= NOP_WORD;
      flush_q      <= 1'b1;
      pmem_rd_en_q <= 1'b0;
      fetch_buf_q  <= NOP_WORD;
    end else begin
      q_phase_q    <= phase_t'(q_phase_q + 2'd1);
      // Strobe is registered, so raise it on the edge entering Q2
      pmem_rd_en_q <= (q_phase_q == Q1);
      // Memory data is valid the clock after the strobe, i.e. during Q3
      if (q_phase_q == Q3) begin
        fetch_buf_q <= bus.pmem_rdata;
      end
      if (q_phase_q == Q4) begin
        if (bus.branch_en) begin
          // Prefetched word is from the wrong path: drop it
          pc_q    <= bus.branch_addr;
          instr_q <= NOP_WORD;
          flush_q <= 1'b1;
        end else begin
          if (bus.incr_pc_en) begin
            pc_q <= pc_q + PC_WIDTH'(1);
          end
          if (bus.instr_rd_en) begin
            instr_q <= fetch_buf_q;
            flush_q <= 1'b0;
          end else begin
            instr_q <= NOP_WORD;
            flush_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.pmem_addr     = pc_q;
  assign bus.pmem_rd_en    = pmem_rd_en_q;
  assign bus.instr_current = instr_q;
  assign bus.pc            = pc_q;
  assign bus.q_phase       = q_phase_q;
  assign bus.flush_active  = flush_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: an instruction-cycle level model
// pushes the expected Q4 result when the controls are driven; the result is
// popped and compared after the Q4 edge.
module tb_instruction_fetch;

  localparam int unsigned PCW = 13;
  localparam int unsigned IW  = 14;
  localparam logic [IW-1:0] NOP = 14'h0000;

  typedef struct {
    logic [IW-1:0]  instr;
    logic           flush;
    logic [PCW-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  instruction_fetch_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus ();

  instruction_fetch #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .RESET_VECTOR(13'h0000),
    .NOP_WORD    (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [1 << PCW];

  // Synchronous program memory: data one clock after the read strobe
  always @(posedge clk) begin
    if (bus.pmem_rd_en) bus.pmem_rdata <= mem[bus.pmem_addr];
  end

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];

  logic [PCW-1:0] m_pc;
  logic [IW-1:0]  m_instr;
  logic           m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q_phase"}, 32'(bus.q_phase), 32'd0);
    check({tag, "_pc"}, 32'(bus.pc), 32'd0);
    check({tag, "_instr"}, 32'(bus.instr_current), 32'(NOP));
    check({tag, "_flush"}, 32'(bus.flush_active), 32'd1);
    check({tag, "_rd_en"}, 32'(bus.pmem_rd_en), 32'd0);
  endtask

  task automatic set_model_reset();
    m_pc    = '0;
    m_instr = NOP;
    m_flush = 1'b1;
    sb_q.delete();
  endtask

  task automatic drive_idle();
    bus.instr_rd_en = 1'b0;
    bus.incr_pc_en  = 1'b0;
    bus.branch_en   = 1'b0;
    bus.branch_addr = '0;
  endtask

  task automatic drive_noise();
    bus.instr_rd_en = 1'($urandom);
    bus.incr_pc_en  = 1'($urandom);
    bus.branch_en   = 1'($urandom);
    bus.branch_addr = PCW'($urandom);
  endtask

  // Mid-cycle checks: fetch state holds, strobe only in q_phase 1
  task automatic check_hold(input string tag, input int ph);
    check({tag, "_q_phase"}, 32'(bus.q_phase), 32'(ph));
    check({tag, "_rd_en"}, 32'(bus.pmem_rd_en), (ph == 1) ? 32'd1 : 32'd0);
    check({tag, "_pc"}, 32'(bus.pc), 32'(m_pc));
    check({tag, "_addr"}, 32'(bus.pmem_addr), 32'(m_pc));
    check({tag, "_instr"}, 32'(bus.instr_current), 32'(m_instr));
    check({tag, "_flush"}, 32'(bus.flush_active), 32'(m_flush));
  endtask

  // One instruction cycle; entered at the negedge in Q1 (q_phase==0)
  task automatic run_cycle(input string tag, input logic rd, input logic incr,
                           input logic br, input logic [PCW-1:0] addr, input bit noise);
    exp_t e;
    if (noise) drive_noise(); else drive_idle();
    @(posedge clk); @(negedge clk);
    if (noise) drive_noise();
    check_hold({tag, "_q2"}, 1);
    @(posedge clk); @(negedge clk);
    if (noise) drive_noise();
    check_hold({tag, "_q3"}, 2);
    @(posedge clk); @(negedge clk);
    check_hold({tag, "_q4"}, 3);
    bus.instr_rd_en = rd;
    bus.incr_pc_en  = incr;
    bus.branch_en   = br;
    bus.branch_addr = addr;
    e.instr = br ? NOP : (rd ? mem[m_pc] : NOP);
    e.flush = br ? 1'b1 : ~rd;
    e.pc    = br ? addr : (incr ? m_pc + PCW'(1) : m_pc);
    sb_q.push_back(e);
    @(posedge clk); @(negedge clk);
    drive_idle();
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_instr"}, 32'(bus.instr_current), 32'(e.instr));
      check({tag, "_flush"}, 32'(bus.flush_active), 32'(e.flush));
      check({tag, "_pc"}, 32'(bus.pc), 32'(e.pc));
      check({tag, "_q_phase"}, 32'(bus.q_phase), 32'd0);
      check({tag, "_rd_en_q1"}, 32'(bus.pmem_rd_en), 32'd0);
      m_pc    = e.pc;
      m_instr = e.instr;
      m_flush = e.flush;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << PCW); i++) mem[i] = IW'($urandom);
    mem[0]      = 14'h3005;
    mem[1]      = 14'h0085;
    mem[13'h100] = 14'h2A5C;
    mem[13'h1FFF] = 14'h1234;

    drive_idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_model_reset();
    check_reset_state("reset");

    // Sequential run from reset vector
    for (int i = 0; i < 5; i++) run_cycle("run", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Branch at pc=5 wins over increment; next cycle loads target word
    run_cycle("branch", 1'b1, 1'b1, 1'b1, 13'h0100, 1'b0);
    run_cycle("branch_tgt", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Skip: NOP presented, pc still advances
    run_cycle("skip", 1'b0, 1'b1, 1'b0, '0, 1'b0);
    run_cycle("after_skip", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Hold pc: same word fetched again
    run_cycle("hold", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    run_cycle("after_hold", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Controls toggling outside Q4 have no effect
    for (int i = 0; i < 4; i++) run_cycle("noise", 1'b1, 1'b1, 1'b0, '0, 1'b1);

    // PC wraparound
    run_cycle("wrap_br", 1'b1, 1'b0, 1'b1, 13'h1FFF, 1'b0);
    run_cycle("wrap_inc", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    run_cycle("wrap_zero", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Reset in Q3 of a branch-flush cycle
    run_cycle("pre_rst_br", 1'b1, 1'b1, 1'b1, 13'h0100, 1'b0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("midrst_pre_phase", 32'(bus.q_phase), 32'd2);
    bus.branch_en = 1'b1;
    bus.incr_pc_en = 1'b1;
    bus.branch_addr = 13'h0ABC;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive_idle();
    set_model_reset();
    check_reset_state("midrst");
    run_cycle("post_rst0", 1'b1, 1'b1, 1'b0, '0, 1'b0);
    run_cycle("post_rst1", 1'b1, 1'b1, 1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
